// File: rtl/fsm_input_conditioner_if.sv
// fsm_input_conditioner_if
//   Groups the button inputs and conditioned outputs of the input conditioner.
//   master : drives the raw buttons and observes the conditioned outputs
//   slave  : the conditioner itself
//   Signals:
//     btn_go_raw, btn_jmp_raw : asynchronous raw push buttons
//     go, jmp                 : debounced levels
//     go_rise, jmp_rise       : one-cycle rising-edge pulses
//     chatter_cnt             : saturating count of aborted debounce attempts
interface fsm_input_conditioner_if;
    logic       btn_go_raw;
    logic       btn_jmp_raw;
    logic       go;
    logic       jmp;
    logic       go_rise;
    logic       jmp_rise;
    logic [7:0] chatter_cnt;

    modport master (
        output btn_go_raw, btn_jmp_raw,
        input  go, jmp, go_rise, jmp_rise, chatter_cnt
    );

    modport slave (
        input  btn_go_raw, btn_jmp_raw,
        output go, jmp, go_rise, jmp_rise, chatter_cnt
    );
endinterface

// File: rtl/fsm_input_conditioner.sv
// fsm_input_conditioner
//   Synchronizes and debounces the go/jmp push buttons for the lab control FSM.
//   Each channel has a 2-flop synchronizer followed by a 4-state counter-based
//   debouncer. A level change is accepted after DEB_CYCLES consecutive identical
//   synchronized samples.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : synchronous active-low reset
//     bus   : slave side of fsm_input_conditioner_if (raw buttons in; go, jmp,
//             go_rise, jmp_rise, chatter_cnt out, all registered)
module fsm_input_conditioner #(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fsm_input_conditioner_if.slave bus
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } deb_state_e;

    typedef struct packed {
        deb_state_e       state;
        logic [CNT_W-1:0] cnt;
        logic             level;
    } chan_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam chan_t CHAN_RST = '{state: STABLE_LO, cnt: '0, level: 1'b0};

    // One debounce step for a channel; abort flags a PEND state falling back
    // to its stable state because of a mismatching sample.
    function automatic chan_t deb_step(input chan_t cur, input logic s, output logic abort);
        chan_t nxt;
        nxt   = cur;
        abort = 1'b0;
        case (cur.state)
            STABLE_LO: begin
                if (s) begin
                    if (DEB_CYCLES == 1) begin
                        nxt.state = STABLE_HI;
                        nxt.level = 1'b1;
                    end else begin
                        nxt.state = PEND_HI;
                        nxt.cnt   = CNT_W'(1);
                    end
                end
            end
            PEND_HI: begin
                if (!s) begin
                    nxt.state = STABLE_LO;
                    nxt.cnt   = '0;
                    abort     = 1'b1;
                end else if (cur.cnt == CNT_LAST) begin
                    nxt.state = STABLE_HI;
                    nxt.cnt   = '0;
                    nxt.level = 1'b1;
                end else begin
                    nxt.cnt = cur.cnt + 1'b1;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    if (DEB_CYCLES == 1) begin
                        nxt.state = STABLE_LO;
                        nxt.level = 1'b0;
                    end else begin
                        nxt.state = PEND_LO;
                        nxt.cnt   = CNT_W'(1);
                    end
                end
            end
            PEND_LO: begin
                if (s) begin
                    nxt.state = STABLE_HI;
                    nxt.cnt   = '0;
                    abort     = 1'b1;
                end else if (cur.cnt == CNT_LAST) begin
                    nxt.state = STABLE_LO;
                    nxt.cnt   = '0;
                    nxt.level = 1'b0;
                end else begin
                    nxt.cnt = cur.cnt + 1'b1;
                end
            end
            default: nxt = CHAN_RST;
        endcase
        return nxt;
    endfunction

    // bit 0 = go channel, bit 1 = jmp channel
    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    chan_t      go_ch_q, go_ch_d;
    chan_t      jmp_ch_q, jmp_ch_d;
    logic       go_rise_q, go_rise_d;
    logic       jmp_rise_q, jmp_rise_d;
    logic [7:0] chatter_cnt_q, chatter_cnt_d;
    logic [8:0] chatter_sum;
    logic       abort_go;
    logic       abort_jmp;

    always_comb begin
        sync1_d     = {bus.btn_jmp_raw, bus.btn_go_raw};
        sync2_d     = sync1_q;
        abort_go    = 1'b0;
        abort_jmp   = 1'b0;
        go_ch_d     = deb_step(go_ch_q, sync2_q[0], abort_go);
        jmp_ch_d    = deb_step(jmp_ch_q, sync2_q[1], abort_jmp);
        // The pulse is registered alongside the level, so both appear together.
        go_rise_d   = go_ch_d.level & ~go_ch_q.level;
        jmp_rise_d  = jmp_ch_d.level & ~jmp_ch_q.level;
        // Both channels may abort on the same edge; 9 bits catch the overflow.
        chatter_sum = {1'b0, chatter_cnt_q} + 9'(abort_go) + 9'(abort_jmp);
        chatter_cnt_d = chatter_sum[8] ? '1 : chatter_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            go_ch_q       <= CHAN_RST;
            jmp_ch_q      <= CHAN_RST;
            go_rise_q     <= 1'b0;
            jmp_rise_q    <= 1'b0;
            chatter_cnt_q <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            go_ch_q       <= go_ch_d;
            jmp_ch_q      <= jmp_ch_d;
            go_rise_q     <= go_rise_d;
            jmp_rise_q    <= jmp_rise_d;
            chatter_cnt_q <= chatter_cnt_d;
        end
    end

    assign bus.go          = go_ch_q.level;
    assign bus.jmp         = jmp_ch_q.level;
    assign bus.go_rise     = go_rise_q;
    assign bus.jmp_rise    = jmp_rise_q;
    assign bus.chatter_cnt = chatter_cnt_q;

endmodule

// File: doc/fsm_input_conditioner.md
# fsm_input_conditioner

Conditions the two push-button inputs that drive the lab control FSM. Each raw button passes through a 2-flop synchronizer and a counter-based debouncer. The block outputs clean levels `go` and `jmp` that connect directly to the FSM's `go`/`jmp` inputs. It also outputs one-cycle rising-edge pulses and a saturating chatter counter for board bring-up.

## Interface

Parameters:
- DEB_CYCLES, default 16: consecutive identical synchronized samples required to accept a level change; legal range 1 .. 2^CNT_W-1.
- CNT_W, default 8: width of each channel's debounce counter.

Ports:
- clk  input  1  system clock; all flops rising-edge.
- rst_n  input  1  reset, synchronous, active-low.
- btn_go_raw  input  1  asynchronous raw go button.
- btn_jmp_raw  input  1  asynchronous raw jmp button.
- go  output  1  debounced go level (registered).
- jmp  output  1  debounced jmp level (registered).
- go_rise  output  1  one-cycle pulse, high in the first cycle `go` is 1.
- jmp_rise  output  1  one-cycle pulse, high in the first cycle `jmp` is 1.
- chatter_cnt  output  8  saturating count of aborted debounce attempts, both channels combined.

## Operation

- Synchronizer: two flops per channel, `s = ff2`. Both flops reset to 0.
- Per-channel debounce FSM, 4 states:
  - STABLE_LO (output 0):
    - `s==1` and DEB_CYCLES==1 -> STABLE_HI.
    - `s==1` otherwise -> PEND_HI, cnt<=1.
  - PEND_HI (output 0):
    - `s==0` -> STABLE_LO, abort.
    - `s==1` and cnt==DEB_CYCLES-1 -> STABLE_HI.
    - `s==1` otherwise -> cnt<=cnt+1.
  - STABLE_HI (output 1): mirror of STABLE_LO, entering PEND_LO on `s==0`.
  - PEND_LO (output 1): mirror of PEND_HI; `s==1` -> STABLE_HI with abort; completing the count -> STABLE_LO.
- Level output:
  - `go`/`jmp` is a register set when entering STABLE_HI and cleared when entering STABLE_LO.
  - The output never changes while the channel is in a PEND state.
- Edge pulse:
  - `go_rise` is registered and asserted in exactly the cycle `go` first reads 1.
  - There is no pulse on the falling edge.
  - Back-to-back presses each produce exactly one pulse.
- Abort accounting:
  - Each PEND->STABLE return caused by a mismatching sample counts as one abort.
  - If both channels abort in the same cycle, `chatter_cnt` increments by 2.
  - `chatter_cnt` saturates at 255 and never wraps; at 254 with a double abort it becomes 255.
- Channels are fully independent; simultaneous presses are debounced in parallel with no priority.

## Timing

- Reset: after any clock edge with rst_n=0:
  - go=0, jmp=0, go_rise=0, jmp_rise=0, chatter_cnt=0.
  - Both FSMs in STABLE_LO, cnt=0, sync flops 0.
- Reset asserted mid-debounce discards the pending count; the pending change is not accepted.
- After reset release with a button held high, the press is accepted as a fresh change, with full latency.
- Latency: raw change stable from before edge E0 updates the output after edge E0+1+DEB_CYCLES.
  - This is 2 synchronizer edges plus DEB_CYCLES samples, total DEB_CYCLES+2 edges counting E0.
  - Release latency is identical to press latency.
- `go_rise` is high during the cycle following edge E0+1+DEB_CYCLES and low at the next edge.
- Glitch rejection: a pulse shorter than DEB_CYCLES synchronized samples never reaches the output.
- Minimum accepted pulse width is DEB_CYCLES cycles.
- Counter never exceeds DEB_CYCLES-1, so it cannot wrap.
- Downstream FSM samples `go`/`jmp` directly; no extra register stage is allowed between them.

## Test plan

Run with DEB_CYCLES=4 unless noted.

- Reset: hold rst_n=0 for 3 edges with both buttons toggling -> all outputs 0 and chatter_cnt=0 throughout. After release with inputs low, outputs stay 0.
- Clean press: btn_go_raw 0->1 before edge 10 and held -> go rises after edge 15, go_rise=1 for exactly one cycle (between edges 15 and 16), jmp stays 0. Release before edge 30 -> go falls after edge 35, no pulse.
- Bounce: btn_jmp_raw high for 2 cycles, low 1, high 3, low 1, then high steady -> jmp rises exactly 6 edges (DEB_CYCLES+2) after the last 0->1 transition. chatter_cnt ends at 2, and jmp_rise fires once.
- Simultaneous: both buttons rise before the same edge -> go and jmp rise on the same edge and both pulses fire in the same cycle. Both buttons then glitch 2 cycles at once -> chatter_cnt increments by 2 in one cycle.
- Reset mid-debounce: press go, assert rst_n=0 at edge 3 of PEND_HI for one edge, keep the button held -> go=0 through reset. After release, go rises 6 edges after the first edge with rst_n=1.
- Saturation / DEB_CYCLES=1: force 300 single-cycle glitches with DEB_CYCLES=4 -> chatter_cnt stops at 255. Rebuild with DEB_CYCLES=1: a press before edge E0 -> go high after edge E0+2, and a 1-cycle glitch passes through.
